// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-select encodings and
// the layout of one scoreboard entry {vld, rd, ld}.
package hazard_scoreboard_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Entry layout, LSB first: ld, rd[aw-1:0], vld
    localparam int unsigned ENT_LD_BIT = 0;
    localparam int unsigned ENT_RD_LSB = 1;

    function automatic int unsigned ent_vld_bit(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned ent_width(input int unsigned aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against one scoreboard entry.
// Register 0 never matches.
module hazard_match #(
    parameter int unsigned AW = 5
) (
    input  logic          use_en,
    input  logic [AW-1:0] src,
    input  logic          ent_vld,
    input  logic [AW-1:0] ent_rd,
    output logic          hit
);

    assign hit = use_en & (src != '0) & ent_vld & (ent_rd == src);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection / forwarding unit beside the ID stage.
// Tracks in-flight destinations for EX, MEM, WB and stalls ID on RAW hazards.
// Optional macro HAZARD_FORWARD_EN: enables EX operand forwarding, so only
// load-use hazards stall; when undefined, forward selects are tied to regfile.
// State updates on the falling clock edge to match the pipeline registers.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned RF_WRITE_THRU = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_regwr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned EW = ent_width(REG_AW);
    localparam int unsigned VB = ent_vld_bit(REG_AW);
`ifdef HAZARD_FORWARD_EN
    // With forwarding only the EX entry (load-use) can force a stall.
    localparam int unsigned NCHK = 1;
`else
    localparam int unsigned NCHK = (RF_WRITE_THRU != 0) ? DEPTH - 1 : DEPTH;
`endif

    logic [EW-1:0]    entry_q [DEPTH];
    logic [NCHK-1:0]  id_hit_rs;
    logic [NCHK-1:0]  id_hit_rt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             unused_ent;

    for (genvar k = 0; k < NCHK; k++) begin : g_id_chk
        hazard_match #(.AW(REG_AW)) u_rs (
            .use_en  (id_use_rs),
            .src     (id_rs),
            .ent_vld (entry_q[k][VB]),
            .ent_rd  (entry_q[k][VB-1:ENT_RD_LSB]),
            .hit     (id_hit_rs[k])
        );
        hazard_match #(.AW(REG_AW)) u_rt (
            .use_en  (id_use_rt),
            .src     (id_rt),
            .ent_vld (entry_q[k][VB]),
            .ent_rd  (entry_q[k][VB-1:ENT_RD_LSB]),
            .hit     (id_hit_rt[k])
        );
    end

    // Stall request; flush kills the ID instruction so it never stalls.
    always_comb begin
`ifdef HAZARD_FORWARD_EN
        stall = id_valid & ~flush & entry_q[0][ENT_LD_BIT] & (id_hit_rs[0] | id_hit_rt[0]);
`else
        stall = id_valid & ~flush & (|(id_hit_rs | id_hit_rt));
`endif
    end

    // Scoreboard shift: ID enters EX slot, or a bubble on stall/flush.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) entry_q[k] <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) entry_q[k] <= entry_q[k-1];
            if (flush || stall) begin
                entry_q[0] <= '0;
            end else begin
                entry_q[0] <= {id_valid & id_regwr & (id_rd != '0), id_rd, id_is_load};
            end
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef HAZARD_FORWARD_EN
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic              ex_use_rs_q;
    logic              ex_use_rt_q;
    logic [1:0]        ex_hit_rs;  // [0] MEM, [1] WB
    logic [1:0]        ex_hit_rt;
    logic              mem_not_ld;

    // EX-stage source latch; a bubble carries no operand uses.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
        end else if (flush || stall) begin
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
        end else begin
            ex_rs_q     <= id_rs;
            ex_rt_q     <= id_rt;
            ex_use_rs_q <= id_valid & id_use_rs;
            ex_use_rt_q <= id_valid & id_use_rt;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_ex_chk
        hazard_match #(.AW(REG_AW)) u_rs (
            .use_en  (ex_use_rs_q),
            .src     (ex_rs_q),
            .ent_vld (entry_q[s+1][VB]),
            .ent_rd  (entry_q[s+1][VB-1:ENT_RD_LSB]),
            .hit     (ex_hit_rs[s])
        );
        hazard_match #(.AW(REG_AW)) u_rt (
            .use_en  (ex_use_rt_q),
            .src     (ex_rt_q),
            .ent_vld (entry_q[s+1][VB]),
            .ent_rd  (entry_q[s+1][VB-1:ENT_RD_LSB]),
            .hit     (ex_hit_rt[s])
        );
    end

    // A load in MEM has no data yet; the load-use stall keeps it from matching.
    assign mem_not_ld = ~entry_q[1][ENT_LD_BIT];

    // Forward select: MEM (youngest) over WB over regfile.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (ex_hit_rs[0] && mem_not_ld) fwd_a_sel = FWD_MEM;
        else if (ex_hit_rs[1])          fwd_a_sel = FWD_WB;
        if (ex_hit_rt[0] && mem_not_ld) fwd_b_sel = FWD_MEM;
        else if (ex_hit_rt[1])          fwd_b_sel = FWD_WB;
    end
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // Entry bits not consumed in every configuration.
    always_comb begin
        unused_ent = id_is_load;
        for (int unsigned k = 0; k < DEPTH; k++) unused_ent = unused_ent ^ (^entry_q[k]);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (default and HAZARD_FORWARD_EN builds).
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic        id_regwr = 1'b0, id_is_load = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        stall, stall_s;
    logic [1:0]  fa, fb, fa_s, fb_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    int unsigned checks = 0;
    int unsigned errors = 0;
    string       phase = "init";
    logic [15:0] m_cnt = '0;
    logic [1:0]  m_cnt_s = '0;

    typedef struct {
        logic        st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr), .stall(stall),
        .fwd_a_sel(fa), .fwd_b_sel(fb), .stall_cnt(cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr), .stall(stall_s),
        .fwd_a_sel(fa_s), .fwd_b_sel(fb_s), .stall_cnt(cnt_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw,
                         input logic [4:0] rd, input logic ld, input logic fl,
                         input logic clr);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_regwr = rw; id_rd = rd; id_is_load = ld; flush = fl; cnt_clr = clr;
    endtask

    // One cycle: drive ID, queue the expectation, compare before the falling edge.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] rd, input logic ld, input logic fl,
                        input logic clr, input logic es, input logic [1:0] efa,
                        input logic [1:0] efb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, rs, rt, urs, urt, rw, rd, ld, fl, clr);
        e.st = es; e.fa = efa; e.fb = efb; e.cnt = m_cnt; e.cnt_s = m_cnt_s;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        check_eq("stall", {31'd0, stall}, {31'd0, e.st});
        check_eq("stall_s", {31'd0, stall_s}, {31'd0, e.st});
        check_eq("fwd_a", {30'd0, fa}, {30'd0, e.fa});
        check_eq("fwd_b", {30'd0, fb}, {30'd0, e.fb});
        check_eq("fwd_a_s", {30'd0, fa_s}, {30'd0, e.fa});
        check_eq("fwd_b_s", {30'd0, fb_s}, {30'd0, e.fb});
        check_eq("cnt", {16'd0, cnt}, {16'd0, e.cnt});
        check_eq("cnt_sat", {30'd0, cnt_s}, {30'd0, e.cnt_s});
        // Counter model: clear wins, otherwise saturating increment on stall.
        if (clr) begin
            m_cnt = '0;
            m_cnt_s = '0;
        end else if (es) begin
            if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
            if (m_cnt_s != 2'b11) m_cnt_s = m_cnt_s + 2'd1;
        end
    endtask

    task automatic idle(input logic [1:0] efa, input logic [1:0] efb, input logic clr);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, clr, 1'b0, efa, efb);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) idle(2'b00, 2'b00, 1'b0);
    endtask

    // lw $r then add rs=$r: 1 bubble with forwarding (then WB forward), else 3.
    task automatic load_use(input logic [4:0] r, input logic clr_first);
        int n_st;
        n_st = FWD ? 1 : 3;
        step(1, 5'd1, 5'd0, 1, 0, 1, r, 1, 0, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < n_st; i++)
            step(1, r, 5'd0, 1, 0, 0, 5'd0, 0, 0, (i == 0) ? clr_first : 1'b0, 1, 2'b00, 2'b00);
        step(1, r, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(FWD ? 2'b10 : 2'b00, 2'b00, 1'b0);
        idle(2'b00, 2'b00, 1'b0);
        idle(2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        phase = "reset";
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_fwd_a", {30'd0, fa}, 32'd0);
        check_eq("rst_fwd_b", {30'd0, fb}, 32'd0);
        check_eq("rst_cnt", {16'd0, cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        phase = "load_use";
        load_use(5'd5, 1'b0);

        // Reset asserted while a stall is pending clears everything at once.
        phase = "rst_mid";
        step(1, 5'd1, 5'd0, 1, 0, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
        @(posedge clk);
        #1 drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0);
        #2 check_eq("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_mid_fa", {30'd0, fa}, 32'd0);
        check_eq("rst_mid_cnt", {16'd0, cnt}, 32'd0);
        check_eq("rst_mid_cnt_s", {30'd0, cnt_s}, 32'd0);
        m_cnt = '0;
        m_cnt_s = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        drain();

        // ALU writer $3, reader uses $3 on rt and $0 on rs.
        phase = "raw_alu";
        step(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0, 0, 2'b00, 2'b00);
`ifdef HAZARD_FORWARD_EN
        step(1, 5'd0, 5'd3, 1, 1, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(2'b00, 2'b01, 1'b0);
        drain();
`else
        for (int i = 0; i < 3; i++)
            step(1, 5'd0, 5'd3, 1, 1, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00);
        step(1, 5'd0, 5'd3, 1, 1, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        drain();
`endif

        // Two writers of $2 back to back, then a reader of $2 on both ports.
        phase = "b2b";
        step(1, 5'd1, 5'd1, 1, 1, 1, 5'd2, 0, 0, 0, 0, 2'b00, 2'b00);
        step(1, 5'd3, 5'd4, 1, 1, 1, 5'd2, 0, 0, 0, 0, 2'b00, 2'b00);
`ifdef HAZARD_FORWARD_EN
        step(1, 5'd2, 5'd2, 1, 1, 1, 5'd7, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(2'b01, 2'b01, 1'b0);
        drain();
`else
        for (int i = 0; i < 3; i++)
            step(1, 5'd2, 5'd2, 1, 1, 1, 5'd7, 0, 0, 0, 1, 2'b00, 2'b00);
        step(1, 5'd2, 5'd2, 1, 1, 1, 5'd7, 0, 0, 0, 0, 2'b00, 2'b00);
        drain();
`endif

        phase = "zero_reg";
        step(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        step(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        drain();

        // Flushed reader of $7 must not stall and must leave a bubble in EX.
        phase = "flush";
        step(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 0, 0, 0, 0, 2'b00, 2'b00);
        step(1, 5'd7, 5'd0, 1, 0, 1, 5'd9, 1, 1, 0, 0, 2'b00, 2'b00);
        step(1, 5'd9, 5'd0, 1, 0, 1, 5'd8, 0, 0, 0, 0, 2'b00, 2'b00);
        drain();

        // Saturation in the 2-bit instance, then clear coinciding with a stall.
        phase = "counter";
        idle(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < (FWD ? 5 : 2); i++) load_use(5'd4, 1'b0);
        phase = "cnt_clr";
        load_use(5'd6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
